// File: rtl/wb_burst_mixer.sv
// -----------------------------------------------------------------------------
// wb_burst_mixer
//
// Purpose: arbitrates among NCH DMA channel engines and holds the grant for a
// whole burst, which ends on the beat flagged with last. The granted channel's
// beats pass through a single registered output stage with a valid/ready
// handshake toward a shared Wishbone-side datapath.
//
// Optional feature, selected by the macro MIXER_FIXED_PRIO_EN:
//   undefined - round-robin arbitration. The pointer remembers the channel
//               that finished last, and the scan starts just after it.
//   defined   - fixed priority, where the highest index wins. No pointer is
//               kept.
//
// Parameters:
//   NCH  number of input channels (2..16)
//   DW   data width per channel
//
// Ports:
//   wb_clk_i   in   clock, rising edge
//   wb_rst_i   in   synchronous active-high reset
//   req_i      in   [NCH]     per-channel beat valid
//   dat_i      in   [NCH*DW]  packed channel data, channel k at [k*DW +: DW]
//   last_i     in   [NCH]     per-channel final-beat-of-burst flag
//   ack_o      out  [NCH]     beat accepted from channel k (combinational)
//   gnt_o      out  [NCH]     registered one-hot grant
//   o_valid    out            output beat valid
//   o_dat      out  [DW]      output data
//   o_last     out            output beat is last of its burst
//   o_src      out  [NCH]     one-hot source channel of the output beat
//   o_ready    in             downstream accepts when o_valid & o_ready
// -----------------------------------------------------------------------------
module wb_burst_mixer #(
    parameter int NCH = 5,
    parameter int DW  = 32
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [NCH-1:0]    req_i,
    input  logic [NCH*DW-1:0] dat_i,
    input  logic [NCH-1:0]    last_i,
    output logic [NCH-1:0]    ack_o,
    output logic [NCH-1:0]    gnt_o,
    output logic              o_valid,
    output logic [DW-1:0]     o_dat,
    output logic              o_last,
    output logic [NCH-1:0]    o_src,
    input  logic              o_ready
);

    localparam int IW = $clog2(NCH);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [NCH-1:0]   gnt_q, gnt_d;
    logic [IW-1:0]    gidx_q, gidx_d;
    logic             o_valid_q;
    logic [DW-1:0]    o_dat_q;
    logic             o_last_q;
    logic [NCH-1:0]   o_src_q;

    logic [IW-1:0]    win_idx;
    logic [DW-1:0]    ch_dat [NCH];
    logic [DW-1:0]    sel_dat;
    logic             sel_last;
    logic             space;
    logic             beat_acc;

    // Unpack the flat data bus so that the granted channel's data can be
    // selected by index.
    for (genvar gi = 0; gi < NCH; gi++) begin : g_unpack
        assign ch_dat[gi] = dat_i[gi*DW +: DW];
    end

    assign sel_dat  = ch_dat[gidx_q];
    assign sel_last = last_i[gidx_q];

    // The output register can take a new beat when it is empty, or when it
    // is being drained in this same cycle.
    assign space    = ~o_valid_q | o_ready;
    assign beat_acc = (state_q == BUSY) & req_i[gidx_q] & space;

`ifdef MIXER_FIXED_PRIO_EN
    // The ascending scan overwrites win_idx, so the highest set index wins.
    always_comb begin
        win_idx = '0;
        for (int i = 0; i < NCH; i++) begin
            if (req_i[i]) win_idx = IW'(i);
        end
    end
`else
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW:0]   cand;
    logic          found;

    // Scan ptr+1 .. ptr+NCH modulo NCH. The sum is always below 2*NCH, so a
    // single conditional subtract performs the wrap.
    always_comb begin
        win_idx = '0;
        cand    = '0;
        found   = 1'b0;
        for (int i = 1; i <= NCH; i++) begin
            cand = {1'b0, ptr_q} + (IW+1)'(i);
            if (cand >= (IW+1)'(NCH)) cand = cand - (IW+1)'(NCH);
            if (!found && req_i[cand[IW-1:0]]) begin
                win_idx = cand[IW-1:0];
                found   = 1'b1;
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        ack_o   = '0;
`ifndef MIXER_FIXED_PRIO_EN
        ptr_d   = ptr_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << win_idx;
                    gidx_d  = win_idx;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (beat_acc && !wb_rst_i) ack_o[gidx_q] = 1'b1;
                if (beat_acc && sel_last) begin
                    gnt_d   = '0;
                    state_d = IDLE;
`ifndef MIXER_FIXED_PRIO_EN
                    ptr_d   = gidx_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            gidx_q    <= '0;
            o_valid_q <= 1'b0;
            o_dat_q   <= '0;
            o_last_q  <= 1'b0;
            o_src_q   <= '0;
`ifndef MIXER_FIXED_PRIO_EN
            ptr_q     <= IW'(NCH-1);
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
`ifndef MIXER_FIXED_PRIO_EN
            ptr_q   <= ptr_d;
`endif
            // A new beat takes priority over draining. If both happen in the
            // same cycle, the register is reloaded and valid stays high.
            if (beat_acc) begin
                o_dat_q   <= sel_dat;
                o_last_q  <= sel_last;
                o_src_q   <= gnt_q;
                o_valid_q <= 1'b1;
            end else if (o_valid_q && o_ready) begin
                o_valid_q <= 1'b0;
            end
        end
    end

    assign gnt_o   = gnt_q;
    assign o_valid = o_valid_q;
    assign o_dat   = o_dat_q;
    assign o_last  = o_last_q;
    assign o_src   = o_src_q;

endmodule

// File: tb/tb_wb_burst_mixer.sv
// -----------------------------------------------------------------------------
// tb_wb_burst_mixer
//
// Directed bench for wb_burst_mixer with NCH=5 and DW=32. Each channel is
// modelled as a source that holds a list of beats. A source presents its head
// beat and advances when it sees ack_o. The expected output beats are pushed
// to a scoreboard queue as the stimulus is set up. They are popped and
// compared whenever the downstream handshake (o_valid & o_ready) occurs.
// -----------------------------------------------------------------------------
module tb_wb_burst_mixer;

    localparam int NCH = 5;
    localparam int DW  = 32;

    typedef struct packed {
        logic [DW-1:0]  d;
        logic           l;
        logic [NCH-1:0] s;
    } beat_t;

    logic              clk;
    logic              rst;
    logic [NCH-1:0]    req_i;
    logic [NCH*DW-1:0] dat_i;
    logic [NCH-1:0]    last_i;
    logic [NCH-1:0]    ack_o;
    logic [NCH-1:0]    gnt_o;
    logic              o_valid;
    logic [DW-1:0]     o_dat;
    logic              o_last;
    logic [NCH-1:0]    o_src;
    logic              o_ready;

    wb_burst_mixer #(.NCH(NCH), .DW(DW)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .req_i    (req_i),
        .dat_i    (dat_i),
        .last_i   (last_i),
        .ack_o    (ack_o),
        .gnt_o    (gnt_o),
        .o_valid  (o_valid),
        .o_dat    (o_dat),
        .o_last   (o_last),
        .o_src    (o_src),
        .o_ready  (o_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int    total = 0;
    int    bad   = 0;
    beat_t sbq[$];

    logic [DW:0] cmem  [NCH][32];
    int          chead [NCH];
    int          ccnt  [NCH];
    logic        msk   [NCH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int k, input logic [DW-1:0] d, input logic l);
        cmem[k][ccnt[k]] = {l, d};
        ccnt[k]++;
    endtask

    task automatic push(input logic [DW-1:0] d, input logic l, input logic [NCH-1:0] s);
        beat_t b;
        b.d = d;
        b.l = l;
        b.s = s;
        sbq.push_back(b);
    endtask

    task automatic drive();
        for (int k = 0; k < NCH; k++) begin
            if (chead[k] < ccnt[k]) begin
                req_i[k]            = !msk[k];
                dat_i[k*DW +: DW]   = cmem[k][chead[k]][DW-1:0];
                last_i[k]           = cmem[k][chead[k]][DW];
            end else begin
                req_i[k]            = 1'b0;
                dat_i[k*DW +: DW]   = '0;
                last_i[k]           = 1'b0;
            end
        end
    endtask

    // Take one clock cycle. The handshake and the acks are sampled mid-cycle,
    // before the edge. The sources advance after the edge and are redriven.
    task automatic cyc();
        logic [NCH-1:0] acked;
        beat_t          e;
        if (o_valid === 1'b1 && o_ready === 1'b1) begin
            total++;
            assert (sbq.size() != 0) else begin
                bad++;
                $error("FAIL sb_extra observed=%0h expected=none", o_dat);
            end
            if (sbq.size() != 0) begin
                e = sbq.pop_front();
                chk("sb_beat", {o_dat, o_last, o_src}, {e.d, e.l, e.s});
            end
        end
        acked = ack_o;
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++) begin
            if (acked[k] === 1'b1) chead[k]++;
        end
        drive();
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            cyc();
            n++;
        end
        chk(tag, sbq.size(), 0);
        repeat (3) cyc();
    endtask

    initial begin
        rst     = 1'b1;
        o_ready = 1'b1;
        req_i   = '0;
        dat_i   = '0;
        last_i  = '0;
        for (int k = 0; k < NCH; k++) begin
            chead[k] = 0;
            ccnt[k]  = 0;
            msk[k]   = 1'b0;
        end

        // ---- 1: reset with all channels requesting
        for (int k = 0; k < NCH; k++) load(k, 32'h100 + k, 1'b1);
        drive();
        #1;
        for (int c = 0; c < 2; c++) begin
            cyc();
            chk("rst_ack", ack_o, 0);
            chk("rst_gnt", gnt_o, 0);
            chk("rst_valid", o_valid, 0);
            chk("rst_dat", o_dat, 0);
            chk("rst_last", o_last, 0);
            chk("rst_src", o_src, 0);
        end
        rst = 1'b0;
`ifdef MIXER_FIXED_PRIO_EN
        for (int k = NCH-1; k >= 0; k--) push(32'h100 + k, 1'b1, 5'(1 << k));
        cyc();
        chk("first_gnt", gnt_o, 5'b10000);
`else
        for (int k = 0; k < NCH; k++) push(32'h100 + k, 1'b1, 5'(1 << k));
        cyc();
        chk("first_gnt", gnt_o, 5'b00001);
`endif
        drain("t1_drain");

        // ---- 2: single three-beat burst on ch2
        load(2, 32'hA0, 1'b0);
        load(2, 32'hA1, 1'b0);
        load(2, 32'hA2, 1'b1);
        push(32'hA0, 1'b0, 5'b00100);
        push(32'hA1, 1'b0, 5'b00100);
        push(32'hA2, 1'b1, 5'b00100);
        drive();
        #1;
        cyc();
        chk("t2_gnt", gnt_o, 5'b00100);
        chk("t2_ack", ack_o, 5'b00100);
        cyc();
        chk("t2_b0", {o_valid, o_dat, o_last, o_src}, {1'b1, 32'hA0, 1'b0, 5'b00100});
        cyc();
        chk("t2_b1", {o_valid, o_dat, o_last, o_src}, {1'b1, 32'hA1, 1'b0, 5'b00100});
        cyc();
        chk("t2_b2", {o_valid, o_dat, o_last, o_src}, {1'b1, 32'hA2, 1'b1, 5'b00100});
        chk("t2_gnt_off", gnt_o, 0);
        drain("t2_drain");

        // ---- 3: ch1 and ch3 competing with single-beat bursts (fresh pointer)
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        load(1, 32'h21, 1'b1);
        load(1, 32'h22, 1'b1);
        load(3, 32'h71, 1'b1);
        load(3, 32'h72, 1'b1);
`ifdef MIXER_FIXED_PRIO_EN
        push(32'h71, 1'b1, 5'b01000);
        push(32'h72, 1'b1, 5'b01000);
        push(32'h21, 1'b1, 5'b00010);
        push(32'h22, 1'b1, 5'b00010);
`else
        push(32'h21, 1'b1, 5'b00010);
        push(32'h71, 1'b1, 5'b01000);
        push(32'h22, 1'b1, 5'b00010);
        push(32'h72, 1'b1, 5'b01000);
`endif
        drive();
        #1;
        drain("t3_drain");

        // ---- 4: backpressure on a ch0 four-beat burst
        for (int i = 0; i < 4; i++) begin
            load(0, 32'h10 + i, (i == 3));
            push(32'h10 + i, (i == 3), 5'b00001);
        end
        drive();
        #1;
        cyc();
        cyc();
        o_ready = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_ack_blk", ack_o, 0);
            chk("t4_hold", {o_valid, o_dat, o_src}, {1'b1, 32'h10, 5'b00001});
            cyc();
        end
        o_ready = 1'b1;
        #1;
        drain("t4_drain");

        // ---- 5: ch4 drops req mid-burst while ch1 requests
        load(4, 32'h40, 1'b0);
        load(4, 32'h41, 1'b0);
        load(4, 32'h42, 1'b1);
        push(32'h40, 1'b0, 5'b10000);
        push(32'h41, 1'b0, 5'b10000);
        push(32'h42, 1'b1, 5'b10000);
        push(32'h50, 1'b1, 5'b00010);
        drive();
        #1;
        cyc();
        cyc();
        msk[4] = 1'b1;
        load(1, 32'h50, 1'b1);
        drive();
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("t5_gnt_hold", gnt_o, 5'b10000);
            chk("t5_ack_none", ack_o, 0);
            cyc();
        end
        msk[4] = 1'b0;
        drive();
        #1;
        chk("t5_gnt_b1", gnt_o, 5'b10000);
        chk("t5_ack_b1", ack_o, 5'b10000);
        cyc();
        chk("t5_ack_b2", ack_o, 5'b10000);
        cyc();
        chk("t5_idle_gnt", gnt_o, 0);
        chk("t5_idle_ack", ack_o, 0);
        cyc();
        chk("t5_gnt_ch1", gnt_o, 5'b00010);
        drain("t5_drain");

        // ---- 6: reset pulsed on beat 2 of a ch3 burst
        for (int i = 0; i < 4; i++) load(3, 32'h30 + i, (i == 3));
        push(32'h30, 1'b0, 5'b01000);
        drive();
        #1;
        cyc();
        cyc();
        rst = 1'b1;
        #1;
        chk("t6_rst_ack", ack_o, 0);
        cyc();
        chk("t6_rst_gnt", gnt_o, 0);
        chk("t6_rst_out", {o_valid, o_dat, o_last, o_src}, 0);
        rst = 1'b0;
        load(0, 32'h60, 1'b1);
`ifdef MIXER_FIXED_PRIO_EN
        for (int i = 1; i < 4; i++) push(32'h30 + i, (i == 3), 5'b01000);
        push(32'h60, 1'b1, 5'b00001);
        drive();
        #1;
        cyc();
        chk("t6_gnt", gnt_o, 5'b01000);
`else
        push(32'h60, 1'b1, 5'b00001);
        for (int i = 1; i < 4; i++) push(32'h30 + i, (i == 3), 5'b01000);
        drive();
        #1;
        cyc();
        chk("t6_gnt", gnt_o, 5'b00001);
`endif
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_burst_mixer.md
Name: wb_burst_mixer

Overview:
- Parametrised N-channel, W-bit successor to the 5-channel 1-bit grant-selected mixer.
- Arbitrates among NCH requesting channels and holds the grant for a whole burst (until `last`).
- Muxes the granted channel's data into a registered output stage with valid/ready handshake.
- Sits between DMA channel engines and a shared Wishbone-side datapath.

Parameters:
- NCH, 5, number of input channels (2..16).
- DW, 32, data width per channel.

Ports:
- wb_clk_i  in  1  clock, all logic on rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- req_i  in  NCH  per-channel beat valid.
- dat_i  in  NCH*DW  packed channel data; channel k at bits [k*DW +: DW].
- last_i  in  NCH  per-channel final-beat-of-burst flag.
- ack_o  out  NCH  beat accepted from channel k (combinational).
- gnt_o  out  NCH  registered one-hot grant.
- o_valid  out  1  output beat valid.
- o_dat  out  DW  output data.
- o_last  out  1  output beat is last of burst.
- o_src  out  NCH  one-hot source channel of current output beat.
- o_ready  in  1  downstream accepts beat when o_valid & o_ready.

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values: gnt_o=0, o_valid=0, o_dat=0, o_last=0, o_src=0. Round-robin pointer ptr=NCH-1, so channel 0 has first priority. State=IDLE.
- While wb_rst_i is high, ack_o is forced to 0.
- State machine: IDLE and BUSY.
- IDLE:
  - gnt_o=0, ack_o=0.
  - If any req_i bit is set, select the winner round-robin: scan ptr+1, ptr+2, ... mod NCH; the first set bit wins.
  - Next cycle: gnt_o = one-hot winner, state=BUSY. Grant latency is 1 cycle from req.
  - If no request, stay in IDLE.
- BUSY, granted channel g:
  - space = ~o_valid | o_ready.
  - ack_o[g] = req_i[g] & space; all other ack_o bits are 0.
  - On ack: o_dat<=dat_i[g], o_last<=last_i[g], o_src<=gnt_o, o_valid<=1.
  - Else if o_valid & o_ready: o_valid<=0; o_dat, o_last and o_src hold.
  - Ack with last_i[g]=1: gnt_o<=0, ptr<=g, state<=IDLE.
  - If req_i[g] drops mid-burst: grant is held, no ack, other channels are ignored until g's last beat.
- Output stability: while o_valid & ~o_ready, o_dat, o_last and o_src must not change. No beat is dropped or duplicated.
- Throughput:
  - 1 beat/cycle within a burst when o_ready=1.
  - One IDLE bubble cycle between bursts. A single-beat burst therefore costs 2 cycles.
- Simultaneous events: ack and downstream accept in the same cycle means a new beat is loaded and o_valid stays 1.
- Reset mid-burst: the burst is abandoned, all outputs take their reset values on the next edge, and ptr returns to NCH-1.
- No tristate output. The idle output is a driven register (o_valid=0).

Optional Feature:
- Macro: MIXER_FIXED_PRIO_EN.
- Defined: arbitration in IDLE is fixed priority, highest index wins (NCH-1 over ... over 0). ptr is not updated or used. Burst hold behaviour is unchanged.
- Undefined: round-robin as specified above.

Test Plan (NCH=5, DW=32):
1. Reset: assert wb_rst_i 2 cycles with req_i=5'b11111 -> ack_o=0, gnt_o=0, o_valid=0, o_dat=0 throughout. After release, channel 0 is granted first.
2. Single burst: ch2 req with data 0xA0,0xA1,0xA2, last on 0xA2, o_ready=1:
   - gnt_o=5'b00100 one cycle after req.
   - o_dat sequence 0xA0,0xA1,0xA2 on consecutive cycles, o_src=5'b00100, o_last=1 only with 0xA2.
   - gnt_o=0 the cycle after the last ack.
3. Round-robin: ch1 and ch3 each continuously present single-beat bursts (last=1) -> o_src order 00010,01000,00010,01000. With MIXER_FIXED_PRIO_EN -> always 01000.
4. Backpressure: ch0 4-beat burst 0x10..0x13, o_ready=0 for 4 cycles after the first beat ->
   - ack_o[0]=0 while o_valid & ~o_ready.
   - o_dat holds 0x10 stable.
   - After release, downstream receives 0x10,0x11,0x12,0x13 exactly once each.
5. Hold: ch4 granted, drops req_i[4] for 3 cycles mid-burst while ch1 requests -> gnt_o stays 5'b10000 and ack_o[1]=0 until ch4's last beat. ch1 is granted after the IDLE cycle.
6. Reset mid-burst: wb_rst_i pulsed on beat 2 of a ch3 burst -> next cycle gnt_o=0 and o_valid=0. With ch0 and ch3 both requesting afterwards, ch0 wins.
